// File: rtl/mux_sel_rr_scheduler_pkg.sv
// Shared state type and default parameters for the round-robin mux-select scheduler.
package mux_sched_pkg;

  typedef enum logic {IDLE, GRANT} sched_state_t;

  localparam int N_DEF        = 8;
  localparam int SEL_W_DEF    = 3;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/mux_sel_rr_scheduler_rr_pick_next.sv
// Combinational round-robin picker: the first set bit of cand strictly after index last,
// wrapping modulo N, built as a rotating double-width priority encoder.
module rr_pick_next
  import mux_sched_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N-1:0]     cand,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SEL_W:0]   start;
  logic [SEL_W-1:0] off;

  // Rotating the doubled vector puts index last+1 at bit 0, so the lowest set bit wins.
  always_comb begin
    start = {1'b0, last} + (SEL_W+1)'(1);
    dbl   = {cand, cand};
    rot   = dbl[start +: N];
    found = |rot;
    off   = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    idx    = last + off + SEL_W'(1);
    onehot = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/mux_sel_rr_scheduler.sv
// Round-robin scheduler owning the select of a shared N:1 mux; grants are held until released.
// Optional hold timeout with preemption is enabled by defining MUX_SCHED_HOLD_TIMEOUT_EN.
module mux_sel_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic             preempt
);

  if (N != 2**SEL_W) begin : g_bad_width
    $error("mux_sel_rr_scheduler: N must equal 2**SEL_W");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("mux_sel_rr_scheduler: MAX_HOLD must be at least 2");
  end

  sched_state_t     state;
  logic [SEL_W-1:0] last;
  logic             owner_req;
  logic             hold_expired;
  logic [N-1:0]     pick_cand;
  logic [SEL_W-1:0] pick_last;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;

`ifdef MUX_SCHED_HOLD_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD);
  logic [HC_W-1:0] hold_cnt;
  assign hold_expired = (hold_cnt == HC_W'(MAX_HOLD-1));
`else
  assign hold_expired = 1'b0;
  assign preempt      = 1'b0;
`endif

  assign owner_req = |(req & gnt);
  assign gnt_valid = |gnt;

  // While granted, the owner is excluded and becomes the new rotation origin.
  always_comb begin
    pick_cand = req;
    pick_last = last;
    if (state == GRANT) begin
      pick_cand = req & ~gnt;
      pick_last = sel;
    end
  end

  rr_pick_next #(.N(N), .SEL_W(SEL_W)) u_pick (
    .cand   (pick_cand),
    .last   (pick_last),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= SEL_W'(N-1);
      sel   <= '0;
      gnt   <= '0;
`ifdef MUX_SCHED_HOLD_TIMEOUT_EN
      hold_cnt <= '0;
      preempt  <= 1'b0;
`endif
    end else begin
`ifdef MUX_SCHED_HOLD_TIMEOUT_EN
      preempt  <= 1'b0;
      hold_cnt <= (state == GRANT && owner_req && !hold_expired) ? hold_cnt + HC_W'(1) : '0;
`endif
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state <= GRANT;
            gnt   <= pick_onehot;
            sel   <= pick_idx;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            last <= sel;
            if (en && pick_found) begin
              gnt <= pick_onehot;
              sel <= pick_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else if (hold_expired && en && pick_found) begin
            last <= sel;
            gnt  <= pick_onehot;
            sel  <= pick_idx;
`ifdef MUX_SCHED_HOLD_TIMEOUT_EN
            preempt <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
